// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M unit placed beside the ALU in EX.
// It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op, stalls the
// pipeline while the op runs, and returns one result with a single-cycle
// done pulse. Multiply is one registered full product. Divide is restoring,
// one quotient bit per cycle, followed by a sign-fixup cycle.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   start   : launch op (only honoured in IDLE)
//   flush   : abort the in-flight op; also drops a start seen in IDLE
//   op      : 5-bit ALU select code (ALU_MUL..ALU_REMU are legal)
//   rs1     : dividend / multiplicand, captured on an accepted start
//   rs2     : divisor / multiplier, captured on an accepted start
//   busy    : high whenever the unit is not IDLE
//   done    : one-cycle pulse; result is valid in the same cycle
//   result  : held from done until the next op completes
//   stall   : combinational pipeline hold
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  // ALU select codes for the RV32M group
  localparam logic [OP_W-1:0] ALU_MUL    = 5'd16;
  localparam logic [OP_W-1:0] ALU_MULH   = 5'd17;
  localparam logic [OP_W-1:0] ALU_MULHSU = 5'd18;
  localparam logic [OP_W-1:0] ALU_MULHU  = 5'd19;
  localparam logic [OP_W-1:0] ALU_DIV    = 5'd20;
  localparam logic [OP_W-1:0] ALU_DIVU   = 5'd21;
  localparam logic [OP_W-1:0] ALU_REM    = 5'd22;
  localparam logic [OP_W-1:0] ALU_REMU   = 5'd23;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Decode of the incoming op
  logic op_legal, in_is_div, in_signed, in_is_rem, rs2_zero, in_ovf, accept;

  always_comb begin
    op_legal  = (op >= ALU_MUL) && (op <= ALU_REMU);
    in_is_div = (op >= ALU_DIV);
    in_signed = (op == ALU_DIV) || (op == ALU_REM);
    in_is_rem = (op == ALU_REM) || (op == ALU_REMU);
    rs2_zero  = (rs2 == '0);
    in_ovf    = in_signed && (rs1 == SMIN) && (rs2 == '1);
    accept    = (state_q == S_IDLE) && start && op_legal && !flush;
  end

  // Full-width product of the captured operands, sign-extended per op
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] a_ext, b_ext, product;

  always_comb begin
    mul_a_sgn = (op_q != ALU_MULHU);
    mul_b_sgn = (op_q == ALU_MUL) || (op_q == ALU_MULH);
    a_ext     = {{XLEN{mul_a_sgn & a_q[XLEN-1]}}, a_q};
    b_ext     = {{XLEN{mul_b_sgn & b_q[XLEN-1]}}, b_q};
    product   = a_ext * b_ext;
  end

  // One restoring step: shift rem:quot left, trial-subtract the divisor
  logic [XLEN:0] rem_shift, trial;
  logic          trial_ok;
  logic          q_is_rem;

  always_comb begin
    rem_shift = {rem_q, quot_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvsr_q};
    trial_ok  = ~trial[XLEN];
    q_is_rem  = (op_q == ALU_REM) || (op_q == ALU_REMU);
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op;
          a_d  = rs1;
          b_d  = rs2;
          if (!in_is_div) begin
            state_d = S_MUL;
          end else if (rs2_zero) begin
            // Divide by zero: quotient all ones, remainder is the dividend
            state_d  = S_DONE;
            result_d = in_is_rem ? rs1 : '1;
          end else if (in_ovf) begin
            state_d  = S_DONE;
            result_d = in_is_rem ? '0 : SMIN;
          end else begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(XLEN);
            quot_d  = (in_signed && rs1[XLEN-1]) ? -rs1 : rs1;
            dvsr_d  = (in_signed && rs2[XLEN-1]) ? -rs2 : rs2;
            rem_d   = '0;
            negq_d  = in_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            negr_d  = in_signed && rs1[XLEN-1];
          end
        end
      end

      S_MUL: begin
        result_d = (op_q == ALU_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end

      S_DIV: begin
        rem_d  = trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], trial_ok};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (q_is_rem) begin
          result_d = negr_q ? -rem_q : rem_q;
        end else begin
          result_d = negq_q ? -quot_q : quot_q;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: back to IDLE with the previous result untouched
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  // Hold covers the launch cycle itself, so it must see start combinationally
  assign stall  = accept | (busy_q & ~done_q);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam logic [31:0] SMIN      = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [4:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done, stall;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_exp = 32'd0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural RV32M result computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == SMIN) && (b == 32'hFFFF_FFFF);
    case (o)
      ALU_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
      ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      ALU_MULHSU: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
      ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? SMIN : 32'(sa / sb);
      ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o < ALU_DIV) return 2;
    if (b == 0) return 1;
    if (((o == ALU_DIV) || (o == ALU_REM)) && (a == SMIN) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return SMIN;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op, scramble rs1/rs2 after capture, then check timing and result
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int k;
    int lat;
    logic bad;
    lat = ref_latency(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1 check({tag, "/stall_c0"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0; rs1 = $urandom; rs2 = $urandom;
    k = 1; bad = 1'b0;
    while (done !== 1'b1 && k <= 40) begin
      if (stall !== 1'b1 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check({tag, "/latency"}, 32'(k), 32'(lat));
    check({tag, "/result"}, result, exp);
    check({tag, "/busy_stall_at_done"}, 32'({busy, stall}), 32'd2);
    check({tag, "/hold_while_running"}, 32'(bad), 32'd0);
    @(negedge clk);
    check({tag, "/idle_after"}, 32'({busy, done, stall}), 32'd0);
    check({tag, "/result_held"}, result, exp);
    last_exp = exp;
  endtask

  initial begin
    int k;
    logic saw;
    logic [4:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = ALU_MUL; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    check("reset/outputs", 32'({busy, done, stall}), 32'd0);
    check("reset/result", result, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    run_op(ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
    run_op(ALU_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, "div_m20_3");
    run_op(ALU_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, "rem_m20_3");
    run_op(ALU_REMU,   32'd100,        32'd7,         32'd2,         "remu_100_7");
    run_op(ALU_DIVU,   32'd100,        32'd7,         32'd14,        "divu_100_7");
    run_op(ALU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by0");
    run_op(ALU_REM,    32'd5,          32'd0,         32'd5,         "rem_by0");
    run_op(ALU_DIV,    SMIN,           32'hFFFF_FFFF, SMIN,          "div_ovf");
    run_op(ALU_REM,    SMIN,           32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    run_op(ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_m1");
    run_op(ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         "mulh_m1");
    run_op(ALU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    run_op(ALU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         "mul_m1");

    // Illegal op with start is ignored
    @(negedge clk);
    start = 1'b1; op = 5'd3; rs1 = 32'd9; rs2 = 32'd9;
    #1 check("illegal/stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("illegal/busy", 32'({busy, done}), 32'd0);

    // Flush in IDLE drops a concurrent start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = ALU_MUL; rs1 = 32'd2; rs2 = 32'd2;
    #1 check("flush_idle/stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_idle/busy", 32'({busy, done}), 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = ALU_MUL + 5'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("rnd%0d_op%0d", i, ro));
    end

    // start held while busy is ignored; start in the cycle after done is accepted
    @(negedge clk);
    start = 1'b1; op = ALU_DIVU; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    op = ALU_MUL; rs1 = 32'd3; rs2 = 32'd5;
    k = 1;
    while (done !== 1'b1 && k <= 40) begin
      @(negedge clk);
      k++;
    end
    check("busy_start/latency", 32'(k), 32'd34);
    check("busy_start/result", result, 32'd14);
    @(negedge clk);
    #1 check("b2b/stall_c0", 32'(stall), 32'd1);
    check("b2b/busy_c0", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k <= 40) begin
      @(negedge clk);
      k++;
    end
    check("b2b/latency", 32'(k), 32'd2);
    check("b2b/result", result, 32'd15);
    last_exp = 32'd15;

    // Flush at cycle 10 of a divide
    @(negedge clk);
    start = 1'b1; op = ALU_DIV; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush/busy_done", 32'({busy, done}), 32'd0);
    check("flush/result_kept", result, last_exp);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    check("flush/no_done", 32'(saw), 32'd0);

    // Reset at cycle 5 of a divide
    @(negedge clk);
    start = 1'b1; op = ALU_DIV; rs1 = 32'd100; rs2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset/outputs", 32'({busy, done, stall}), 32'd0);
    check("midreset/result", result, 32'd0);
    rst_n = 1'b1;
    run_op(ALU_DIV, 32'd100, 32'd7, 32'd14, "after_reset_div");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
